// File: rtl/led_pwm_pkg.sv
// ----------------------------------------------------------------------------
// led_pwm_pkg
// Shared types and constants for the LED/GPIO output controller.
//   led_mode_e      : per-channel output mode (OFF, ON, BLINK, PWM)
//   REG_*           : register-select codes within a channel's 4-word window
//   ADDR_*/SEL_*/CH_*: layout of the 6-bit word address on the peripheral bus
// ----------------------------------------------------------------------------
package led_pwm_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_e;

    localparam logic [1:0] REG_MODE   = 2'd0;
    localparam logic [1:0] REG_DUTY   = 2'd1;
    localparam logic [1:0] REG_PERIOD = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // Word address: [5:2] channel index, [1:0] register select.
    localparam int ADDR_W  = 6;
    localparam int SEL_LSB = 0;
    localparam int SEL_W   = 2;
    localparam int CH_LSB  = 2;
    localparam int CH_W    = 4;

endpackage

// File: rtl/led_channel.sv
// ----------------------------------------------------------------------------
// led_channel
// One LED output channel: mode/duty/period registers, blink counter and
// blink state, and the registered LED drive bit.
// Ports:
//   clk, reset        : system clock, asynchronous active-high reset
//   tick              : shared timebase tick (one clk wide)
//   pwm_cnt           : shared free-running PWM counter
//   wr_mode/duty/period: decoded write strobes for this channel
//   wdata_*           : write data already trimmed to each register's width
//   mode/duty/period  : register contents (for read-back)
//   blink_state       : current blink phase (for STATUS read-back)
//   led               : LED drive, active-high, one clk after its cause
// ----------------------------------------------------------------------------
module led_channel
    import led_pwm_pkg::*;
#(
    parameter int PWM_W   = 8,
    parameter int BLINK_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [PWM_W-1:0]   pwm_cnt,
    input  logic               wr_mode,
    input  logic               wr_duty,
    input  logic               wr_period,
    input  logic [1:0]         wdata_mode,
    input  logic [PWM_W-1:0]   wdata_duty,
    input  logic [BLINK_W-1:0] wdata_period,
    output led_mode_e          mode,
    output logic [PWM_W-1:0]   duty,
    output logic [BLINK_W-1:0] period,
    output logic               blink_state,
    output logic               led
);

    logic [BLINK_W-1:0] blink_cnt;
    logic               led_next;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        led_next = 1'b0;
        unique case (mode)
            LED_OFF:   led_next = 1'b0;
            LED_ON:    led_next = 1'b1;
            LED_BLINK: led_next = blink_state;
            LED_PWM:   led_next = (pwm_cnt < duty);
            default:   led_next = 1'b0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode        <= LED_OFF;
            duty        <= '0;
            period      <= '0;
            blink_cnt   <= '0;
            blink_state <= 1'b0;
            led         <= 1'b0;
        end else begin
            if (wr_mode)   mode   <= led_mode_e'(wdata_mode);
            if (wr_duty)   duty   <= wdata_duty;
            if (wr_period) period <= wdata_period;

            // A MODE or PERIOD write restarts the blink phase and takes
            // priority over a coincident tick.
            if (wr_mode || wr_period) begin
                blink_cnt   <= '0;
                blink_state <= 1'b0;
            end else if (tick && mode == LED_BLINK) begin
                if (blink_cnt == period) begin
                    blink_cnt   <= '0;
                    blink_state <= ~blink_state;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            led <= led_next;
        end
    end

endmodule

// File: rtl/led_pwm_ctrl.sv
// ----------------------------------------------------------------------------
// led_pwm_ctrl
// Memory-mapped controller for CHANNELS independently programmable LEDs.
// Holds the shared prescaler and PWM counter, the bus write decode and the
// registered read path; per-channel state lives in led_channel.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   bus_we     : single-cycle write strobe
//   bus_re     : single-cycle read strobe
//   bus_addr   : word address, [5:2] channel, [1:0] register select
//   bus_wdata  : write data (bits above each register's width ignored)
//   bus_rdata  : read data, valid when bus_rvalid=1, held otherwise
//   bus_rvalid : one-cycle pulse, one clk after bus_re
//   led        : LED drive, bit i = channel i, active-high
// ----------------------------------------------------------------------------
module led_pwm_ctrl
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int PWM_W    = 8,
    parameter int BLINK_W  = 16,
    parameter int PRESCALE = 50
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bus_we,
    input  logic                bus_re,
    input  logic [ADDR_W-1:0]   bus_addr,
    input  logic [31:0]         bus_wdata,
    output logic [31:0]         bus_rdata,
    output logic                bus_rvalid,
    output logic [CHANNELS-1:0] led
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [PWM_W-1:0] pwm_cnt;

    logic [CH_W-1:0]  addr_ch;
    logic [SEL_W-1:0] addr_sel;
    logic [31:0]      rd_next;

    led_mode_e          ch_mode   [CHANNELS];
    logic [PWM_W-1:0]   ch_duty   [CHANNELS];
    logic [BLINK_W-1:0] ch_period [CHANNELS];
    logic               ch_blink  [CHANNELS];

    // Only the low bits of the write data reach any register.
    logic unused_wdata;
    assign unused_wdata = ^bus_wdata;

    assign addr_ch  = bus_addr[CH_LSB +: CH_W];
    assign addr_sel = bus_addr[SEL_LSB +: SEL_W];

    // Timebase: tick is high during the last count of each prescaler period.
    assign tick = (pre_cnt == PRE_MAX);

    // NOTE: reset is asynchronous and covers every flop, including the
    // per-channel registers, so outputs drop without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Channels beyond CHANNELS have no instance, so writes to them match
    // nothing and are dropped; STATUS has no write strobe at all.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic wr_hit;
        assign wr_hit = bus_we && (addr_ch == CH_W'(i));

        led_channel #(
            .PWM_W   (PWM_W),
            .BLINK_W (BLINK_W)
        ) u_channel (
            .clk          (clk),
            .reset        (reset),
            .tick         (tick),
            .pwm_cnt      (pwm_cnt),
            .wr_mode      (wr_hit && addr_sel == REG_MODE),
            .wr_duty      (wr_hit && addr_sel == REG_DUTY),
            .wr_period    (wr_hit && addr_sel == REG_PERIOD),
            .wdata_mode   (bus_wdata[1:0]),
            .wdata_duty   (bus_wdata[PWM_W-1:0]),
            .wdata_period (bus_wdata[BLINK_W-1:0]),
            .mode         (ch_mode[i]),
            .duty         (ch_duty[i]),
            .period       (ch_period[i]),
            .blink_state  (ch_blink[i]),
            .led          (led[i])
        );
    end

    // Read mux sees pre-edge register values, so a read coinciding with a
    // write to the same address returns the old contents.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (addr_ch == CH_W'(i)) begin
                unique case (addr_sel)
                    REG_MODE:   rd_next = {30'd0, ch_mode[i]};
                    REG_DUTY:   rd_next = 32'(ch_duty[i]);
                    REG_PERIOD: rd_next = 32'(ch_period[i]);
                    REG_STATUS: rd_next = {30'd0, ch_blink[i], led[i]};
                    default:    rd_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
        end else begin
            bus_rvalid <= bus_re;
            if (bus_re) bus_rdata <= rd_next;
        end
    end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
- Parametrised, memory-mapped LED/GPIO output controller for the priRV32 SoC; replaces the single hard-wired `led` output with CHANNELS independently programmable outputs.
- Sits on the core's simple peripheral bus and drives board LEDs.
- Each channel runs in one of four modes: OFF, ON, BLINK (programmable half-period), PWM (programmable duty).
- All timing derives from a shared prescaler tick.

Parameters:
- CHANNELS, 4, number of LED outputs (1..16).
- PWM_W, 8, PWM counter/duty width in bits.
- BLINK_W, 16, blink half-period register width in bits.
- PRESCALE, 50, clk cycles per timebase tick (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- bus_we  input  1  single-cycle write strobe.
- bus_re  input  1  single-cycle read strobe.
- bus_addr  input  6  word address: [5:2] channel index, [1:0] register select.
- bus_wdata  input  32  write data.
- bus_rdata  output  32  read data; valid when bus_rvalid=1.
- bus_rvalid  output  1  read-data-valid pulse.
- led  output  CHANNELS  LED drive, bit i = channel i, active-high.

Behaviour:
- Reset (async assert, sync release):
  - led=0, bus_rdata=0, bus_rvalid=0.
  - All modes=OFF, duty=0, period=0.
  - Prescaler, PWM counter, blink counters and blink states all 0.
- Register map per channel (reg select):
  - 0 = MODE [1:0]: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
  - 1 = DUTY [PWM_W-1:0].
  - 2 = PERIOD [BLINK_W-1:0].
  - 3 = STATUS, read-only: bit0 = current led bit, bit1 = blink state.
- Writes:
  - Take effect on the clk edge where bus_we=1; upper wdata bits are ignored.
  - A write to STATUS, or to a channel index >= CHANNELS, is ignored.
- Reads:
  - bus_rvalid pulses exactly 1 cycle after bus_re, with bus_rdata registered on that same edge; latency is 1.
  - Unused bits read 0; channel index >= CHANNELS reads 0.
  - When bus_rvalid=0, bus_rdata holds its last value.
- Simultaneous bus_we and bus_re to the same address: the read returns the OLD value and the write still lands.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - `tick` is high for one clk in the cycle the count equals PRESCALE-1.
  - PRESCALE=1 gives tick every cycle.
- PWM counter:
  - Shared, PWM_W bits, increments on tick, wraps 2^PWM_W-1 -> 0.
- Per-channel next-led (registered; led changes on the edge after its cause):
  - OFF: 0.
  - ON: 1.
  - PWM: (pwm_cnt < duty). duty=0 gives constant 0; duty=2^PWM_W-1 gives 1 for all but one count per frame.
  - BLINK:
    - Channel counter increments on tick.
    - When a tick arrives with counter == period: counter <- 0 and blink state toggles.
    - led = blink state.
    - period=0 toggles on every tick.
- A write to MODE or PERIOD clears that channel's blink counter and blink state on the same edge. Writing the current mode value also clears them.
- DUTY writes do not reset any counter and take effect at the next comparison.
- A tick coinciding with a MODE write: the write wins; the counter is cleared, not incremented.
- Reset asserted mid-operation: all outputs drop to reset values immediately (asynchronously).

Decomposition:
- Package led_pwm_pkg holds:
  - mode enum (LED_OFF, LED_ON, LED_BLINK, LED_PWM);
  - register-select constants (REG_MODE=0, REG_DUTY=1, REG_PERIOD=2, REG_STATUS=3);
  - address field width/position localparams.
- One sub-module, led_channel:
  - holds mode/duty/period registers, blink counter and state, and the led output flop;
  - instantiated CHANNELS times via generate.
- The top level holds the prescaler, the PWM counter, write decode and the read mux/register.

Test Plan (PRESCALE=4, PWM_W=8, CHANNELS=4 unless noted):
1. Reset 15 ns after start, then read all 16 registers -> every bus_rdata=0 with bus_rvalid 1 cycle after each bus_re; led=4'b0000.
2. Write ch1 MODE=1 -> led[1]=1 on the edge after the next register update; other bits stay 0. Write MODE=0 -> led[1]=0.
3. ch0 PERIOD=2, MODE=2 -> led[0] toggles every 3 ticks = 12 clk. Rewrite PERIOD=0 mid-phase -> blink state clears to 0, then toggles every 4 clk.
4. ch2 DUTY=64, MODE=3 -> led[2] high for 64 of every 256 ticks (256 of 1024 clk). DUTY=0 gives always 0; DUTY=255 gives 255/256.
5. Same-cycle bus_we+bus_re to ch3 DUTY (old 0x10, new 0x20) -> rdata=0x10, and a subsequent read returns 0x20. A write to STATUS or to channel 5 (CHANNELS=4) changes nothing.
6. Assert reset during active BLINK/PWM -> led=0 immediately without waiting for a clk edge. After release, modes are OFF and the first tick occurs 4 clk later.
